// File: rtl/act_nz_feeder.sv
// act_nz_feeder: zero-skipping activation feeder for the sparse MAC row.
// Buffers up to DEPTH dense vectors of NROW activations and presents up to
// two nonzero activations per cycle (lane0 = lower row index), each paired
// with its row index. All lane outputs are frozen while load is high.
//
// Optional build macro: ACT_NZ_STATS_EN adds the nz_count statistics port.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   in_valid       dense vector valid
//   in_ready       buffer has room (derived from the registered count)
//   in_vec         dense vector, element i = row i
//   load           row load in progress; freezes the feeder
//   out_activation lane activations {lane1, lane0}
//   act_index      lane row indexes {lane1, lane0}
//   out_valid      per-lane valid, lane0 filled first
//   vec_last       current pair is the final pair of its vector
//   nz_count       (ACT_NZ_STATS_EN only) running count of emitted lanes
module act_nz_feeder #(
   parameter int unsigned BW    = 4,
   parameter int unsigned NROW  = 4,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned IW   = (NROW > 1) ? $clog2(NROW) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NROW-1:0][BW-1:0]  in_vec,
   input  logic                     load,
   output logic [1:0][BW-1:0]       out_activation,
   output logic [1:0][IW-1:0]       act_index,
   output logic [1:0]               out_valid,
   output logic                     vec_last
`ifdef ACT_NZ_STATS_EN
   ,
   output logic [15:0]              nz_count
`endif
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef logic [NROW-1:0][BW-1:0] vec_t;

   state_t        state;
   vec_t          buf_q [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [IW-1:0] sp;

   vec_t          head;
   logic          push;
   logic          pop;
   logic          emit;
   logic          l0_found;
   logic          l1_found;
   logic          more_c;
   logic          vec_last_c;
   logic [IW-1:0] l0_idx;
   logic [IW-1:0] l1_idx;
   logic [IW-1:0] sp_adv;
   logic [BW-1:0] l0_act;
   logic [BW-1:0] l1_act;

   // Modulo-DEPTH pointer increment (DEPTH need not fill PW bits).
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Handshake and buffer occupancy.
   always_comb begin
      push       = in_valid && in_ready;
      emit       = !load && (count != '0);
      pop        = emit && vec_last_c;
      count_next = count + CW'(push) - CW'(pop);
   end

   // Find the first two nonzero elements of the head vector at or above sp,
   // and whether any nonzero element remains beyond them.
   always_comb begin
      head     = buf_q[rptr];
      l0_found = 1'b0;
      l1_found = 1'b0;
      more_c   = 1'b0;
      l0_idx   = '0;
      l1_idx   = '0;
      for (int i = 0; i < int'(NROW); i++) begin
         if ((IW'(i) >= sp) && (head[i] != '0)) begin
            if (!l0_found) begin
               l0_found = 1'b1;
               l0_idx   = IW'(i);
            end else if (!l1_found) begin
               l1_found = 1'b1;
               l1_idx   = IW'(i);
            end else begin
               more_c   = 1'b1;
            end
         end
      end
      vec_last_c = !more_c;
      // Only used when more_c is set, so l1_idx < NROW-1 and this cannot wrap.
      sp_adv     = l1_idx + IW'(1);
      l0_act     = l0_found ? head[l0_idx] : '0;
      l1_act     = l1_found ? head[l1_idx] : '0;
   end

   // Vector storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_q[wptr] <= in_vec;
      end
   end

   // Control FSM with registered lane outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         wptr           <= '0;
         rptr           <= '0;
         count          <= '0;
         sp             <= '0;
         in_ready       <= 1'b1;
         out_activation <= '0;
         act_index      <= '0;
         out_valid      <= '0;
         vec_last       <= 1'b0;
`ifdef ACT_NZ_STATS_EN
         nz_count       <= '0;
`endif
      end else begin
         count    <= count_next;
         in_ready <= (count_next < CW'(DEPTH));
         if (push) begin
            wptr <= ptr_inc(wptr);
         end

         if (load) begin
            // Freeze everything; IDLE already presents a cleared output.
            if (state != IDLE) begin
               state <= HOLD;
            end
         end else if (emit) begin
            state             <= SCAN;
            out_activation[0] <= l0_act;
            out_activation[1] <= l1_act;
            act_index[0]      <= l0_idx;
            act_index[1]      <= l1_idx;
            out_valid         <= {l1_found, l0_found};
            vec_last          <= vec_last_c;
            if (vec_last_c) begin
               rptr <= ptr_inc(rptr);
               sp   <= '0;
            end else begin
               sp   <= sp_adv;
            end
`ifdef ACT_NZ_STATS_EN
            nz_count <= nz_count + 16'(l0_found) + 16'(l1_found);
`endif
         end else begin
            // Nothing buffered: drop back to IDLE with cleared outputs.
            state          <= IDLE;
            sp             <= '0;
            out_activation <= '0;
            act_index      <= '0;
            out_valid      <= '0;
            vec_last       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_act_nz_feeder.sv
// Self-checking bench for act_nz_feeder: directed scenarios with fixed
// expected words plus randomized traffic checked against a queue-based model.
module tb_act_nz_feeder;

   localparam int unsigned BW    = 4;
   localparam int unsigned NROW  = 4;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned IW    = 2;
   localparam int unsigned OW    = 4 + 2*BW + 2*IW;

   typedef logic [NROW-1:0][BW-1:0] vec_t;

   logic               clk      = 1'b0;
   logic               reset    = 1'b0;
   logic               in_valid = 1'b0;
   logic               load     = 1'b0;
   vec_t               in_vec   = '0;
   logic               in_ready;
   logic [1:0][BW-1:0] out_activation;
   logic [1:0][IW-1:0] act_index;
   logic [1:0]         out_valid;
   logic               vec_last;
`ifdef ACT_NZ_STATS_EN
   logic [15:0]        nz_count;
`endif

   int vecs  = 0;
   int fails = 0;

   // Reference model state: buffered vectors plus the pair position in the head.
   vec_t               mq[$];
   int                 mpair   = 0;
   logic               m_ready = 1'b1;
   logic [1:0]         m_valid = '0;
   logic               m_last  = 1'b0;
   logic [1:0][BW-1:0] m_act   = '0;
   logic [1:0][IW-1:0] m_idx   = '0;
   logic [15:0]        m_nz    = '0;

   act_nz_feeder #(.BW(BW), .NROW(NROW), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_vec         (in_vec),
      .load           (load),
      .out_activation (out_activation),
      .act_index      (act_index),
      .out_valid      (out_valid),
      .vec_last       (vec_last)
`ifdef ACT_NZ_STATS_EN
      ,
      .nz_count       (nz_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] obs();
      return {in_ready, out_valid, vec_last, out_activation, act_index};
   endfunction

   function automatic logic [OW-1:0] expm();
      return {m_ready, m_valid, m_last, m_act, m_idx};
   endfunction

   function automatic logic [OW-1:0] pk(input logic r, input logic [1:0] v, input logic l,
                                        input int a1, input int a0, input int i1, input int i0);
      return {r, v, l, BW'(a1), BW'(a0), IW'(i1), IW'(i0)};
   endfunction

   function automatic vec_t mkvec(input int e0, input int e1, input int e2, input int e3);
      vec_t v;
      v[0] = BW'(e0);
      v[1] = BW'(e1);
      v[2] = BW'(e2);
      v[3] = BW'(e3);
      return v;
   endfunction

   function automatic vec_t rndvec();
      vec_t v;
      for (int i = 0; i < int'(NROW); i++) begin
         v[i] = ($urandom_range(0, 1) == 1) ? BW'($urandom_range(1, (1 << BW) - 1)) : '0;
      end
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      mpair   = 0;
      m_ready = 1'b1;
      m_valid = '0;
      m_last  = 1'b0;
      m_act   = '0;
      m_idx   = '0;
      m_nz    = '0;
   endtask

   // One clock of the model, evaluated from pre-edge inputs and state:
   // the head vector's nonzero list is chopped into pairs, one pair per
   // unfrozen cycle, max(1, ceil(nnz/2)) cycles per vector.
   task automatic model_step();
      logic pushed;
      vec_t h;
      int   nzi[$];
      int   np;
      pushed = in_valid && m_ready;
      if (!load) begin
         m_valid = '0;
         m_act   = '0;
         m_idx   = '0;
         m_last  = 1'b0;
         if (mq.size() > 0) begin
            h = mq[0];
            for (int i = 0; i < int'(NROW); i++) begin
               if (h[i] != '0) nzi.push_back(i);
            end
            np = (nzi.size() + 1) / 2;
            if (np == 0) np = 1;
            for (int l = 0; l < 2; l++) begin
               if (2*mpair + l < nzi.size()) begin
                  m_valid[l] = 1'b1;
                  m_act[l]   = h[nzi[2*mpair + l]];
                  m_idx[l]   = IW'(nzi[2*mpair + l]);
                  m_nz       = m_nz + 16'd1;
               end
            end
            m_last = (mpair == np - 1);
            if (m_last) begin
               void'(mq.pop_front());
               mpair = 0;
            end else begin
               mpair = mpair + 1;
            end
         end
      end
      if (pushed) mq.push_back(in_vec);
      m_ready = (mq.size() < int'(DEPTH));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         vecs++;
         if (obs() !== pk(1'b1, 2'b00, 1'b0, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL reset cyc%0d got %h want %h", c, obs(), pk(1'b1, 2'b00, 1'b0, 0, 0, 0, 0));
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_basic();
      logic [OW-1:0] e [4];
      e[0] = pk(1'b1, 2'b00, 1'b0, 0, 0, 0, 0);
      e[1] = pk(1'b1, 2'b11, 1'b0, 7, 3, 2, 0);
      e[2] = pk(1'b1, 2'b01, 1'b1, 0, 5, 0, 3);
      e[3] = pk(1'b1, 2'b00, 1'b0, 0, 0, 0, 0);
      in_vec   = mkvec(3, 0, 7, 5);
      in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         in_valid = 1'b0;
         vecs++;
         if (obs() !== e[c]) begin
            fails++;
            $display("FAIL basic cyc%0d got %h want %h", c, obs(), e[c]);
         end
      end
   endtask

   task automatic test_zero_vec();
      logic [OW-1:0] e [3];
      e[0] = pk(1'b1, 2'b00, 1'b0, 0, 0, 0, 0);
      e[1] = pk(1'b1, 2'b00, 1'b1, 0, 0, 0, 0);
      e[2] = pk(1'b1, 2'b00, 1'b0, 0, 0, 0, 0);
      in_vec   = mkvec(0, 0, 0, 0);
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         in_valid = 1'b0;
         vecs++;
         if (obs() !== e[c]) begin
            fails++;
            $display("FAIL zero_vec cyc%0d got %h want %h", c, obs(), e[c]);
         end
      end
   endtask

   task automatic test_load_hold();
      logic [OW-1:0] e [5];
      e[0] = pk(1'b1, 2'b00, 1'b0, 0, 0, 0, 0);
      e[1] = pk(1'b1, 2'b11, 1'b1, 10, 9, 1, 0);
      e[2] = e[1];
      e[3] = e[1];
      e[4] = pk(1'b1, 2'b00, 1'b0, 0, 0, 0, 0);
      in_vec   = mkvec(9, 10, 0, 0);
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         load = (c == 2 || c == 3);
         tick();
         in_valid = 1'b0;
         vecs++;
         if (obs() !== e[c]) begin
            fails++;
            $display("FAIL load_hold cyc%0d got %h want %h", c, obs(), e[c]);
         end
      end
      load = 1'b0;
   endtask

   task automatic test_back_to_back();
      vec_t v [3];
      int   k = 0;
      logic pushed;
      for (int j = 0; j < 3; j++) begin
         v[j] = mkvec($urandom_range(1, 15), $urandom_range(1, 15),
                      $urandom_range(1, 15), $urandom_range(1, 15));
      end
      for (int c = 0; c < 9; c++) begin
         in_valid = (k < 3);
         in_vec   = v[(k < 3) ? k : 2];
         pushed   = in_valid && m_ready;
         tick();
         if (pushed) k++;
         vecs++;
         if (obs() !== expm()) begin
            fails++;
            $display("FAIL b2b_model cyc%0d got %h want %h", c, obs(), expm());
         end
         if (c >= 1 && c <= 6) begin
            vecs++;
            if (out_valid !== 2'b11 || vec_last !== logic'(c % 2 == 0)) begin
               fails++;
               $display("FAIL b2b_nogap cyc%0d got valid=%b last=%b want valid=11 last=%0d",
                        c, out_valid, vec_last, (c % 2 == 0));
            end
         end
         if (c == 1 || c == 2) begin
            vecs++;
            if (in_ready !== logic'(c == 2)) begin
               fails++;
               $display("FAIL b2b_ready cyc%0d got %b want %0d", c, in_ready, (c == 2));
            end
         end
      end
      in_valid = 1'b0;
      vecs++;
      if (k != 3) begin
         fails++;
         $display("FAIL b2b_accepted got %0d want 3", k);
      end
   endtask

   task automatic test_reset_mid();
      in_vec   = mkvec(1, 2, 3, 4);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      vecs++;
      if (obs() !== pk(1'b1, 2'b11, 1'b0, 2, 1, 1, 0)) begin
         fails++;
         $display("FAIL rstmid_pair got %h want %h", obs(), pk(1'b1, 2'b11, 1'b0, 2, 1, 1, 0));
      end
      #2;
      reset = 1'b0;
      #1;
      vecs++;
      if (obs() !== pk(1'b1, 2'b00, 1'b0, 0, 0, 0, 0)) begin
         fails++;
         $display("FAIL rstmid_async got %h want %h", obs(), pk(1'b1, 2'b00, 1'b0, 0, 0, 0, 0));
      end
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         vecs++;
         if (obs() !== expm() || out_valid !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_after cyc%0d got %h want %h", c, obs(), expm());
         end
      end
   endtask

`ifdef ACT_NZ_STATS_EN
   task automatic test_stats();
      for (int c = 0; c < 6; c++) begin
         in_valid = (c < 2);
         in_vec   = (c == 0) ? mkvec(3, 0, 7, 5) : mkvec(0, 0, 0, 0);
         tick();
         vecs++;
         if (obs() !== expm() || nz_count !== m_nz) begin
            fails++;
            $display("FAIL stats_model cyc%0d got %h/%0d want %h/%0d", c, obs(), nz_count, expm(), m_nz);
         end
      end
      in_valid = 1'b0;
      vecs++;
      if (nz_count !== 16'd3) begin
         fails++;
         $display("FAIL stats_total got %0d want 3", nz_count);
      end
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_vec   = rndvec();
         load     = ($urandom_range(0, 4) == 0);
         tick();
         vecs++;
         if (obs() !== expm()) begin
            fails++;
            $display("FAIL random cyc%0d got %h want %h", c, obs(), expm());
         end
`ifdef ACT_NZ_STATS_EN
         vecs++;
         if (nz_count !== m_nz) begin
            fails++;
            $display("FAIL random_nz cyc%0d got %0d want %0d", c, nz_count, m_nz);
         end
`endif
      end
      in_valid = 1'b0;
      load     = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_vec();
      test_load_hold();
      test_back_to_back();
      test_reset_mid();
`ifdef ACT_NZ_STATS_EN
      test_stats();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
